// File: rtl/multdiv_ctrl.sv
// multdiv_ctrl
// Sequencer for the shared multi-cycle multiply/divide unit. A mul/div seen in
// DX is accepted in IDLE, its operands and destination are captured, the unit
// is launched with a one-cycle pulse, and the result (or an exception/timeout
// code aimed at $rstatus) is presented as a single writeback beat.
//
// Ports
//   clock, reset            : clock, asynchronous active-high reset
//   dx_ir, dx_opA, dx_opB   : instruction and bypassed operands in DX
//   md_result, md_exception : unit result / exception (valid with md_resultRDY)
//   md_resultRDY            : unit completion pulse
//   ctrl_MULT, ctrl_DIV     : one-cycle launch pulses
//   md_opA, md_opB          : registered operands held stable to the unit
//   accept                  : op captured at the coming edge
//   mdiv_running            : unit busy (LAUNCH, WAIT)
//   mdiv_ready              : writeback cycle
//   wb_valid, wb_rd, wb_data: register-file write request
//   timeout                 : writeback was forced by the watchdog
module multdiv_ctrl #(
  parameter int TIMEOUT      = 40,
  parameter int RSTATUS_REG  = 30,
  parameter int MUL_EXC_CODE = 4,
  parameter int DIV_EXC_CODE = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] dx_ir,
  input  logic [31:0] dx_opA,
  input  logic [31:0] dx_opB,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_resultRDY,
  output logic        ctrl_MULT,
  output logic        ctrl_DIV,
  output logic [31:0] md_opA,
  output logic [31:0] md_opB,
  output logic        accept,
  output logic        mdiv_running,
  output logic        mdiv_ready,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        timeout
);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_WB} state_t;

  localparam logic [5:0] CNT_LAST   = 6'(TIMEOUT - 1);
  localparam logic [4:0] RSTATUS_RD = 5'(RSTATUS_REG);

  state_t      r_state;
  state_t      w_next;
  logic [5:0]  r_cnt;
  logic        r_is_div;
  logic [4:0]  r_rd;
  logic [31:0] r_opA;
  logic [31:0] r_opB;
  logic [4:0]  r_wb_rd;
  logic [31:0] r_wb_data;
  logic        r_wb_en;
  logic        r_timeout;

  logic w_is_op;
  logic w_done;
  logic w_expire;

  function automatic logic [31:0] exc_code(input logic is_div);
    return is_div ? 32'(DIV_EXC_CODE) : 32'(MUL_EXC_CODE);
  endfunction

  // Case-equality keeps an X/Z instruction from ever decoding as an op.
  assign w_is_op = (dx_ir[31:27] === 5'b00000) &&
                   ((dx_ir[6:2] === 5'b00110) || (dx_ir[6:2] === 5'b00111));

  // Completion sources; the unit's response wins over the watchdog.
  assign w_done   = (r_state == S_WAIT) && md_resultRDY;
  assign w_expire = (r_state == S_WAIT) && !md_resultRDY && (r_cnt == CNT_LAST);

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_is_op) w_next = S_LAUNCH;
      S_LAUNCH: w_next = S_WAIT;
      S_WAIT:   if (w_done || w_expire) w_next = S_WB;
      S_WB:     w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    accept       = 1'b0;
    ctrl_MULT    = 1'b0;
    ctrl_DIV     = 1'b0;
    mdiv_running = 1'b0;
    mdiv_ready   = 1'b0;
    wb_valid     = 1'b0;
    timeout      = 1'b0;
    case (r_state)
      S_IDLE:   accept = w_is_op;
      S_LAUNCH: begin
        ctrl_MULT    = !r_is_div;
        ctrl_DIV     = r_is_div;
        mdiv_running = 1'b1;
      end
      S_WAIT:   mdiv_running = 1'b1;
      S_WB: begin
        mdiv_ready = 1'b1;
        wb_valid   = r_wb_en;
        timeout    = r_timeout;
      end
      default: ;
    endcase
  end

  // Operand/destination capture, watchdog counter and writeback latch.
  // Writeback fields are prepared on the way into WB so they simply hold
  // their values in every other state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt     <= '0;
      r_is_div  <= 1'b0;
      r_rd      <= '0;
      r_opA     <= '0;
      r_opB     <= '0;
      r_wb_rd   <= '0;
      r_wb_data <= '0;
      r_wb_en   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      if (r_state == S_IDLE && w_is_op) begin
        r_opA    <= dx_opA;
        r_opB    <= dx_opB;
        r_rd     <= dx_ir[26:22];
        r_is_div <= dx_ir[2];
      end
      if (r_state == S_LAUNCH) r_cnt <= '0;
      else if (r_state == S_WAIT) r_cnt <= r_cnt + 6'd1;
      if (w_done) begin
        r_timeout <= 1'b0;
        if (md_exception) begin
          r_wb_rd   <= RSTATUS_RD;
          r_wb_data <= exc_code(r_is_div);
          r_wb_en   <= 1'b1;
        end else begin
          r_wb_rd   <= r_rd;
          r_wb_data <= md_result;
          r_wb_en   <= (r_rd != 5'd0);
        end
      end else if (w_expire) begin
        r_timeout <= 1'b1;
        r_wb_rd   <= RSTATUS_RD;
        r_wb_data <= exc_code(r_is_div);
        r_wb_en   <= 1'b1;
      end
    end
  end

  assign md_opA  = r_opA;
  assign md_opB  = r_opB;
  assign wb_rd   = r_wb_rd;
  assign wb_data = r_wb_data;

endmodule
